event_wakeup_unit: RTL and testbench
====================================

// Module: event_wakeup_unit
// PURPOSE
//  Upstream of the sleep unit: collects NUM_LINES event/interrupt lines, latches rising edges into pending bits,
//  drives signal_o (the sleep unit's wake signal_i) and runs an IRQ request/ack handshake with the core.
//  Mask/pending/clear are APB registers. Single clock domain; optional input synchronizers.
// PARAMETERS
//  APB_ADDR_WIDTH  12  APB address width (4KB slave)
//  NUM_LINES       32  event lines, 1..32; line i maps to register bit i, higher bits read 0/ignored
// PORTS
//  HCLK         in   1               clock; all logic on posedge
//  HRESET       in   1               reset, asynchronous, active-high
//  PADDR        in   APB_ADDR_WIDTH  APB address, word index PADDR[4:2]
//  PWDATA       in   32              APB write data
//  PWRITE       in   1               APB write
//  PSEL         in   1               APB select
//  PENABLE      in   1               APB enable
//  PRDATA       out  32              APB read data
//  PREADY       out  1               tied 1
//  PSLVERR      out  1               tied 0
//  events_i     in   NUM_LINES       raw event/interrupt lines, level, rising edge significant
//  irq_o        out  1               interrupt request to core
//  irq_id_o     out  5               index of requested line, stable while irq_o=1
//  irq_ack_i    in   1               1-cycle ack from core for irq_id_o
//  signal_o     out  1               wake/pending indication to sleep unit
// BEHAVIOUR
//  Reset: all regs 0, prev-sample 0, FSM IDLE; irq_o=0, irq_id_o=0, signal_o=0, PRDATA=0.
//  Edge: edge[i] = ev[i] & ~prev[i]; prev <= ev every cycle; line high at reset release counts as an edge.
//  Registers (offset, access):
//   0x00 IRQ_EN  RW  enable line as interrupt
//   0x04 EVT_EN  RW  enable line as wake-only event
//   0x08 PEND    R, write-1-to-set (software trigger)
//   0x0C CLEAR   W1C on PEND; reads 0
//   0x10 ID      R: {irq_o, 26'b0, irq_id_o}
//   others: read 0, writes ignored. Write on PSEL&PENABLE&PWRITE; PRDATA comb., 0 unless PSEL&PENABLE&!PWRITE.
//  PEND next = (PEND & ~clr_apb & ~clr_ack) | edge | set_apb; set beats clear in the same cycle.
//  signal_o = |(PEND & (IRQ_EN|EVT_EN)), combinational from regs: high 1 cycle after sampled edge.
//  FSM (IDLE, REQ, GAP):
//   IDLE: if |(PEND&IRQ_EN): latch lowest set index into irq_id_o, -> REQ.
//   REQ : irq_o=1. irq_ack_i -> clear PEND[id], -> GAP. Else if PEND[id]&IRQ_EN[id]==0 (APB clear/disable)
//         -> IDLE (request withdrawn, irq_o low next cycle). Ack wins over withdraw in same cycle.
//   GAP : irq_o=0 one cycle so core sees a falling edge; -> IDLE.
//  Ack while not in REQ: ignored. Latency events_i rise -> irq_o: 2 cycles (no sync).
//  New edge on acked line in ack cycle: PEND stays 1, re-requested after GAP.
//  HRESET mid-request: irq_o drops asynchronously, pending edges lost.
// CONFIGURATION
//  EVENT_WAKEUP_SYNC_EN defined: 2-flop synchronizer per line before edge detect, +2 cycles to all latencies
//   (irq_o 4 cycles after rise). Undefined: events_i used directly (must be HCLK-synchronous).
// STRUCTURE
//  event_unit_pkg: register offset constants, wakeup FSM state enum, ID width constant (5).
//  Sub-module event_edge_detect (per-vector optional sync + prev register + edge output).
//  Top holds APB regs, pending logic, priority encoder, FSM.
// TESTING
//  IRQ_EN=0x1, pulse events_i[0] -> signal_o=1 next cycle, irq_o=1, irq_id_o=0 cycle after; ack -> PEND=0, irq_o=0.
//  IRQ_EN=0x30, raise lines 4 and 5 together -> irq_id_o=4; ack; GAP; then irq_id_o=5.
//  EVT_EN=0x4, IRQ_EN=0, raise line 2 -> signal_o=1, irq_o stays 0; write CLEAR=0x4 -> signal_o=0.
//  In REQ for line 3, write CLEAR=0x8 -> irq_o=0 next cycle, FSM IDLE, ID reads 0x3 with bit31=0.
//  Edge on line 1 in same cycle as ack of id 1 -> PEND[1] remains 1, irq_o re-asserts after GAP.
//  With EVENT_WAKEUP_SYNC_EN, rise on line 0 -> irq_o at +4 cycles; HRESET mid-REQ -> all outputs 0 immediately.

Source files
------------

// File: rtl/event_unit_pkg.sv
// Shared definitions for the event wakeup unit: register word indices, FSM states,
// IRQ id width and the lowest-set-bit priority helper.
package event_unit_pkg;

  localparam int ID_WIDTH = 5;

  localparam logic [2:0] REG_IRQ_EN = 3'd0;
  localparam logic [2:0] REG_EVT_EN = 3'd1;
  localparam logic [2:0] REG_PEND   = 3'd2;
  localparam logic [2:0] REG_CLEAR  = 3'd3;
  localparam logic [2:0] REG_ID     = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } wakeup_state_e;

  // Line 0 has the highest priority.
  function automatic logic [ID_WIDTH-1:0] lowest_set_index(input logic [31:0] vec);
    logic [ID_WIDTH-1:0] idx;
    logic                found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i] && !found) begin
        idx   = ID_WIDTH'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/event_edge_detect.sv
// Per-line rising-edge detector with an optional 2-flop input synchronizer
// (enabled by defining EVENT_WAKEUP_SYNC_EN).
module event_edge_detect #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_level,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] r_prev;

`ifdef EVENT_WAKEUP_SYNC_EN
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  // Two-stage synchronizer for asynchronous event lines.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_level;
      r_sync2 <= r_sync1;
    end
  end

  assign w_level = r_sync2;
`else
  assign w_level = i_level;
`endif

  // Previous sample clears to 0 so a line already high at reset release reads as an edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_edge = w_level & ~r_prev;

endmodule

// File: rtl/event_wakeup_unit.sv
// Event/interrupt wakeup unit: APB mask and pending registers, rising-edge latching, wake
// signal and IRQ request/ack handshake. Define EVENT_WAKEUP_SYNC_EN for input synchronizers.
module event_wakeup_unit
  import event_unit_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_LINES      = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_LINES-1:0]      events_i,
  output logic                      irq_o,
  output logic [ID_WIDTH-1:0]       irq_id_o,
  input  logic                      irq_ack_i,
  output logic                      signal_o
);

  localparam logic [31:0] LINE_MASK = 32'((64'h1 << NUM_LINES) - 64'h1);

  logic [NUM_LINES-1:0] w_edge_raw;
  logic [31:0]          w_edge;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_addr_ok;
  logic [2:0]           w_reg_idx;

  logic [31:0]          r_irq_en;
  logic [31:0]          r_evt_en;
  logic [31:0]          r_pend;
  logic [31:0]          w_irq_en_nx;
  logic [31:0]          w_evt_en_nx;
  logic [31:0]          w_pend_nx;
  logic [31:0]          w_set_apb;
  logic [31:0]          w_clr_apb;
  logic [31:0]          w_clr_ack;
  logic [31:0]          w_req_vec;

  wakeup_state_e        r_state;
  wakeup_state_e        w_state_nx;
  logic [ID_WIDTH-1:0]  r_irq_id;
  logic [ID_WIDTH-1:0]  w_irq_id_nx;
  logic                 r_irq;
  logic                 r_signal;

  event_edge_detect #(
    .WIDTH (NUM_LINES)
  ) u_edge (
    .i_clk   (HCLK),
    .i_rst   (HRESET),
    .i_level (events_i),
    .o_edge  (w_edge_raw)
  );

  assign w_edge    = 32'(w_edge_raw);
  assign w_wr      = PSEL & PENABLE & PWRITE;
  assign w_rd      = PSEL & PENABLE & ~PWRITE;
  assign w_reg_idx = PADDR[4:2];
  assign w_addr_ok = (PADDR[APB_ADDR_WIDTH-1:5] == '0) && (PADDR[1:0] == 2'b00);

  assign PREADY   = 1'b1;
  assign PSLVERR  = 1'b0;
  assign irq_o    = r_irq;
  assign irq_id_o = r_irq_id;
  assign signal_o = r_signal;

  // APB write decode into next register values and pending set/clear strobes.
  always_comb begin
    w_irq_en_nx = r_irq_en;
    w_evt_en_nx = r_evt_en;
    w_set_apb   = 32'h0;
    w_clr_apb   = 32'h0;
    if (w_wr && w_addr_ok) begin
      case (w_reg_idx)
        REG_IRQ_EN: w_irq_en_nx = PWDATA & LINE_MASK;
        REG_EVT_EN: w_evt_en_nx = PWDATA & LINE_MASK;
        REG_PEND:   w_set_apb   = PWDATA & LINE_MASK;
        REG_CLEAR:  w_clr_apb   = PWDATA;
        default:    w_set_apb   = 32'h0;
      endcase
    end else begin
      w_set_apb = 32'h0;
    end
  end

  // Setting (edge or software) wins over any clear in the same cycle.
  assign w_pend_nx = (r_pend & ~w_clr_apb & ~w_clr_ack) | w_edge | w_set_apb;
  assign w_req_vec = r_pend & r_irq_en;

  // Request FSM: pick lowest pending enabled line, hold it until ack or withdrawal.
  always_comb begin
    w_state_nx  = r_state;
    w_irq_id_nx = r_irq_id;
    w_clr_ack   = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (|w_req_vec) begin
          w_irq_id_nx = lowest_set_index(w_req_vec);
          w_state_nx  = ST_REQ;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (irq_ack_i) begin
          w_clr_ack  = 32'h1 << r_irq_id;
          w_state_nx = ST_GAP;
        end else if (!(r_pend[r_irq_id] && r_irq_en[r_irq_id])) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_state_nx = ST_REQ;
        end
      end
      ST_GAP:  w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Register file, pending bits, FSM state and registered outputs.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_irq_en <= 32'h0;
      r_evt_en <= 32'h0;
      r_pend   <= 32'h0;
      r_state  <= ST_IDLE;
      r_irq_id <= '0;
      r_irq    <= 1'b0;
      r_signal <= 1'b0;
    end else begin
      r_irq_en <= w_irq_en_nx;
      r_evt_en <= w_evt_en_nx;
      r_pend   <= w_pend_nx;
      r_state  <= w_state_nx;
      r_irq_id <= w_irq_id_nx;
      r_irq    <= (w_state_nx == ST_REQ);
      r_signal <= |(w_pend_nx & (w_irq_en_nx | w_evt_en_nx));
    end
  end

  // PRDATA is a pure function of the current access and register state.
  always_comb begin
    PRDATA = 32'h0;
    if (w_rd && w_addr_ok) begin
      case (w_reg_idx)
        REG_IRQ_EN: PRDATA = r_irq_en;
        REG_EVT_EN: PRDATA = r_evt_en;
        REG_PEND:   PRDATA = r_pend;
        REG_CLEAR:  PRDATA = 32'h0;
        REG_ID:     PRDATA = {r_irq, 26'b0, r_irq_id};
        default:    PRDATA = 32'h0;
      endcase
    end else begin
      PRDATA = 32'h0;
    end
  end

endmodule

// File: tb/tb_event_wakeup_unit.sv
// Self-checking bench for event_wakeup_unit: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of pending bits and the IRQ handshake.
module tb_event_wakeup_unit;

  localparam logic [11:0] A_IRQ_EN = 12'h000;
  localparam logic [11:0] A_EVT_EN = 12'h004;
  localparam logic [11:0] A_PEND   = 12'h008;
  localparam logic [11:0] A_CLEAR  = 12'h00C;
  localparam logic [11:0] A_ID     = 12'h010;
`ifdef EVENT_WAKEUP_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] events_i;
  logic        irq_o;
  logic [4:0]  irq_id_o;
  logic        irq_ack_i;
  logic        signal_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_irq_en, m_evt_en, m_pend, m_prev, m_s1, m_s2;
  logic        m_irq, m_gap;
  logic [4:0]  m_id;

  logic [11:0] addr_tbl [7];
  logic [31:0] rd_obs;

  event_wakeup_unit #(.APB_ADDR_WIDTH(12), .NUM_LINES(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .events_i(events_i), .irq_o(irq_o), .irq_id_o(irq_id_o), .irq_ack_i(irq_ack_i),
    .signal_o(signal_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int first_set(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [11:0] a);
    case (a)
      A_IRQ_EN: return m_irq_en;
      A_EVT_EN: return m_evt_en;
      A_PEND:   return m_pend;
      A_ID:     return {m_irq, 26'b0, m_id};
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_irq_en = 0; m_evt_en = 0; m_pend = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
    m_irq = 0; m_gap = 0; m_id = 0;
  endtask

  // One clock: model computed from inputs before the edge, outputs compared after it.
  task automatic step();
    logic [31:0] ev_eff, edg, set_v, clr_v, ack_clr, n_irq_en, n_evt_en;
    logic        wr, n_irq, n_gap;
    logic [4:0]  n_id;
    ev_eff   = (SYNC_LAT != 0) ? m_s2 : events_i;
    edg      = ev_eff & ~m_prev;
    wr       = PSEL && PENABLE && PWRITE;
    set_v    = (wr && PADDR == A_PEND)  ? PWDATA : 32'h0;
    clr_v    = (wr && PADDR == A_CLEAR) ? PWDATA : 32'h0;
    n_irq_en = (wr && PADDR == A_IRQ_EN) ? PWDATA : m_irq_en;
    n_evt_en = (wr && PADDR == A_EVT_EN) ? PWDATA : m_evt_en;
    ack_clr  = 32'h0;
    n_irq = m_irq; n_gap = 1'b0; n_id = m_id;
    if (m_irq) begin
      if (irq_ack_i) begin
        ack_clr[m_id] = 1'b1; n_irq = 1'b0; n_gap = 1'b1;
      end else if (!(m_pend[m_id] && m_irq_en[m_id])) begin
        n_irq = 1'b0;
      end
    end else if (!m_gap && (m_pend & m_irq_en) != 32'h0) begin
      n_id = 5'(first_set(m_pend & m_irq_en)); n_irq = 1'b1;
    end
    @(posedge HCLK);
    m_pend   = (m_pend & ~clr_v & ~ack_clr) | edg | set_v;
    m_irq_en = n_irq_en; m_evt_en = n_evt_en;
    m_irq = n_irq; m_gap = n_gap; m_id = n_id;
    m_prev = ev_eff; m_s2 = m_s1; m_s1 = events_i;
    #1;
    check("irq_o",    {31'b0, irq_o},    {31'b0, m_irq});
    check("irq_id_o", {27'b0, irq_id_o}, {27'b0, m_id});
    check("signal_o", {31'b0, signal_o}, {31'b0, |(m_pend & (m_irq_en | m_evt_en))});
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    step();
    PENABLE = 1'b1;
    step();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] obs);
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    #1;
    check("prdata_setup", PRDATA, 32'h0);
    step();
    PENABLE = 1'b1;
    #1;
    obs = PRDATA;
    check("prdata", PRDATA, exp_read(a));
    step();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    addr_tbl = '{A_IRQ_EN, A_EVT_EN, A_PEND, A_CLEAR, A_ID, 12'h014, 12'h01C};
    HRESET = 1'b1; PADDR = 12'h0; PWDATA = 32'h0; PWRITE = 1'b0; PSEL = 1'b0;
    PENABLE = 1'b0; events_i = 32'h0; irq_ack_i = 1'b0;
    model_reset();
    #1;
    check("rst_irq",    {31'b0, irq_o},    32'h0);
    check("rst_id",     {27'b0, irq_id_o}, 32'h0);
    check("rst_signal", {31'b0, signal_o}, 32'h0);
    check("rst_prdata", PRDATA,            32'h0);
    check("pready",     {31'b0, PREADY},   32'h1);
    check("pslverr",    {31'b0, PSLVERR},  32'h0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK) HRESET = 1'b0;
    for (int i = 0; i < 5; i++) apb_read(addr_tbl[i], rd_obs);

    // Ack while idle is ignored; single line pulse, request and ack.
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
    apb_write(A_IRQ_EN, 32'h1);
    events_i = 32'h1; step(); events_i = 32'h0;
    repeat (SYNC_LAT) step();
    check("s1_signal", {31'b0, signal_o}, 32'h1);
    step();
    check("s1_irq", {31'b0, irq_o}, 32'h1);
    check("s1_id",  {27'b0, irq_id_o}, 32'h0);
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
    check("s1_irq_low", {31'b0, irq_o}, 32'h0);
    apb_read(A_PEND, rd_obs);
    check("s1_pend", rd_obs, 32'h0);

    // Two lines together: lowest first, next after the gap.
    apb_write(A_IRQ_EN, 32'h30);
    events_i = 32'h30; step(); events_i = 32'h0;
    repeat (SYNC_LAT) step();
    step();
    check("s2_id4", {27'b0, irq_id_o}, 32'h4);
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
    step(); step();
    check("s2_irq5", {31'b0, irq_o}, 32'h1);
    check("s2_id5",  {27'b0, irq_id_o}, 32'h5);
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
    step();

    // Wake-only event and software clear.
    apb_write(A_IRQ_EN, 32'h0);
    apb_write(A_EVT_EN, 32'h4);
    events_i = 32'h4; step(); events_i = 32'h0;
    repeat (SYNC_LAT + 1) step();
    check("s3_signal", {31'b0, signal_o}, 32'h1);
    check("s3_noirq",  {31'b0, irq_o},    32'h0);
    apb_write(A_CLEAR, 32'h4);
    check("s3_cleared", {31'b0, signal_o}, 32'h0);

    // Request withdrawn by clearing its pending bit.
    apb_write(A_IRQ_EN, 32'h8);
    events_i = 32'h8; step(); events_i = 32'h0;
    repeat (SYNC_LAT) step();
    step();
    check("s4_id3", {27'b0, irq_id_o}, 32'h3);
    apb_write(A_CLEAR, 32'h8);
    step();
    check("s4_withdrawn", {31'b0, irq_o}, 32'h0);
    apb_read(A_ID, rd_obs);
    check("s4_id_reg", rd_obs, 32'h3);

    // New edge on the acked line in the ack cycle keeps it pending.
    apb_write(A_IRQ_EN, 32'h2);
    events_i = 32'h2; step(); events_i = 32'h0;
    repeat (SYNC_LAT) step();
    step();
    check("s5_id1", {27'b0, irq_id_o}, 32'h1);
    events_i = 32'h2;
    repeat (SYNC_LAT) step();
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0; events_i = 32'h0;
    step(); step();
    check("s5_rereq", {31'b0, irq_o}, 32'h1);
    check("s5_id",    {27'b0, irq_id_o}, 32'h1);
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) events_i = events_i ^ $urandom;
      irq_ack_i = m_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 9))
        0: begin irq_ack_i = 1'b0; apb_write(addr_tbl[$urandom_range(0, 6)], $urandom); end
        1: begin irq_ack_i = 1'b0; apb_read(addr_tbl[$urandom_range(0, 6)], rd_obs); end
        default: step();
      endcase
      irq_ack_i = 1'b0;
    end

    // Asynchronous reset in the middle of a request.
    events_i = 32'h0;
    apb_write(A_EVT_EN, 32'h0);
    apb_write(A_IRQ_EN, 32'h1);
    apb_write(A_CLEAR, 32'hFFFF_FFFF);
    repeat (SYNC_LAT + 3) step();
    events_i = 32'h1; step();
    repeat (SYNC_LAT) step();
    step();
    check("s6_irq", {31'b0, irq_o}, 32'h1);
    #2 HRESET = 1'b1;
    #1;
    check("s6_rst_irq",    {31'b0, irq_o},    32'h0);
    check("s6_rst_id",     {27'b0, irq_id_o}, 32'h0);
    check("s6_rst_signal", {31'b0, signal_o}, 32'h0);
    model_reset();
    @(posedge HCLK);
    @(negedge HCLK) HRESET = 1'b0;
    step();
    repeat (SYNC_LAT) step();
    apb_read(A_PEND, rd_obs);
    check("s6_edge_at_release", rd_obs, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
